// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: shares one seven-segment decoder across NUM_DIGITS panel digits by time-multiplexed scanning.
// Latency: all outputs are registered; a storage command in cycle t reaches dec_in/dec_en no earlier than t+2.
// Backpressure: none; one command per cycle with priority clr_en > push_en > wr_en, lower ones in that cycle are dropped.
//
// Ports:
//   clk, rst              single rising-edge clock, synchronous active-high reset
//   wr_en/wr_idx/wr_data/wr_vis   write one digit value + visibility (wr_idx >= NUM_DIGITS ignored)
//   push_en/push_data     keypad shift-in: new value enters digit 0 (visible), others move up one
//   clr_en                clear all digit values and visibility bits
//   blink_mask            digits that blink (only with SSD_BLINK_EN)
//   dec_in/dec_en         value and enable for the shared decoder
//   dig_sel               one-hot digit select, all-zero during the blanking cycle
//   frame_tick            one-cycle pulse on the first cycle of every new scan frame
//
// Optional feature macro: SSD_BLINK_EN builds the blink phase/frame counter logic.
// Without it blink_mask is ignored and no blink state exists.

module ssd_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100,
  parameter int BLINK_FRAMES = 50,
  parameter int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [3:0]            wr_data,
  input  logic                  wr_vis,
  input  logic                  push_en,
  input  logic [3:0]            push_data,
  input  logic                  clr_en,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic [3:0]            dec_in,
  output logic                  dec_en,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  frame_tick
);

  // Slot counter width; SCAN_DIV >= 2 keeps this at least one bit.
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Digit storage
  // --------------------------------------------------------------------------
  logic [3:0]            digit_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] vis_q;
  logic                  wr_ok;

  // Indices past the last digit are silently dropped.
  assign wr_ok = (int'(wr_idx) < NUM_DIGITS);

  always_ff @(posedge clk) begin
    if (rst || clr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= 4'h0;
      end
      vis_q <= '0;
    end else if (push_en) begin
      // Shift toward the higher digits; the oldest entry falls off the top.
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        digit_q[i] <= digit_q[i-1];
        vis_q[i]   <= vis_q[i-1];
      end
      digit_q[0] <= push_data;
      vis_q[0]   <= 1'b1;
    end else if (wr_en && wr_ok) begin
      digit_q[wr_idx] <= wr_data;
      vis_q[wr_idx]   <= wr_vis;
    end
  end

  // --------------------------------------------------------------------------
  // Scan FSM: one BLANK cycle followed by SCAN_DIV-1 DRIVE cycles per digit
  // --------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    case (state_q)
      ST_BLANK: begin
        state_d = ST_DRIVE;
        cnt_d   = CNT_W'(1);
      end
      ST_DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            // Last digit of the frame; with one digit this fires every slot.
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Blink phase
  // --------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] blank_by_blink;

`ifdef SSD_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0] fcnt_q;
  logic            phase_q;

  // Phase flips on the same edge that schedules frame_tick, so it is stable
  // for the whole of the following frame, BLANK included.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (wrap) begin
      if (fcnt_q == FC_LAST) begin
        fcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  assign blank_by_blink = {NUM_DIGITS{phase_q}} & blink_mask;
`else
  logic blink_mask_unused;
  assign blink_mask_unused = ^blink_mask;
  assign blank_by_blink    = '0;
`endif

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  // Outputs are computed from the next FSM state so the flops line up with the
  // state register: during a BLANK cycle everything reads zero, during DRIVE
  // they reflect the digit being driven. Storage is sampled as currently held,
  // which is what gives commands their two-cycle path to the outputs.
  logic [NUM_DIGITS-1:0] dig_sel_d;
  logic [3:0]            dec_in_d;
  logic                  dec_en_d;

  always_comb begin
    dig_sel_d = '0;
    dec_in_d  = 4'h0;
    dec_en_d  = 1'b0;
    if (state_d == ST_DRIVE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig_sel_d[i] = (idx_d == IDX_W'(i));
      end
      // dec_in shows the stored value even when the digit is hidden; the
      // decoder enable does the blanking.
      dec_in_d = digit_q[idx_d];
      dec_en_d = vis_q[idx_d] & ~blank_by_blink[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dig_sel    <= '0;
      dec_in     <= 4'h0;
      dec_en     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      dig_sel    <= dig_sel_d;
      dec_in     <= dec_in_d;
      dec_en     <= dec_en_d;
      frame_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed and random stimulus for ssd_scan_ctrl against a cycle-position reference model.
// Latency: expected outputs for cycle c use the storage held during cycle c-1.
// Backpressure: not applicable.

module tb_ssd_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int IW = 2;
  localparam int FR = ND * SD;

`ifdef SSD_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [3:0]    wr_data;
  logic          wr_vis;
  logic          push_en;
  logic [3:0]    push_data;
  logic          clr_en;
  logic [ND-1:0] blink_mask;
  logic [3:0]    dec_in;
  logic          dec_en;
  logic [ND-1:0] dig_sel;
  logic          frame_tick;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLINK_FRAMES(BF),
    .IDX_W       (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .wr_vis    (wr_vis),
    .push_en   (push_en),
    .push_data (push_data),
    .clr_en    (clr_en),
    .blink_mask(blink_mask),
    .dec_in    (dec_in),
    .dec_en    (dec_en),
    .dig_sel   (dig_sel),
    .frame_tick(frame_tick)
  );

  int tests = 0;
  int fails = 0;
  int c = 0;   // cycle number since reset release; cycle 1 is digit-0 BLANK

  // Model storage now, and as it was during the previous cycle.
  logic [3:0]    s_dig [ND];
  logic [ND-1:0] s_vis;
  logic [3:0]    p_dig [ND];
  logic [ND-1:0] p_vis;
  logic [ND-1:0] p_mask;

  task automatic model_clear();
    for (int i = 0; i < ND; i++) s_dig[i] = 4'h0;
    s_vis = '0;
  endtask

  task automatic check_outputs();
    int pos, d, sl, frame;
    logic [ND-1:0] e_sel;
    logic [3:0]    e_in;
    logic          e_en, e_ft, ph;
    pos   = (c - 1) % FR;
    d     = pos / SD;
    sl    = pos % SD;
    frame = (c - 1) / FR;
    ph    = BLINK && (((frame / BF) % 2) == 1);
    e_sel = '0;
    e_in  = 4'h0;
    e_en  = 1'b0;
    if (sl != 0) begin
      e_sel[d] = 1'b1;
      e_in     = p_dig[d];
      e_en     = p_vis[d] & ~(ph & p_mask[d]);
    end
    e_ft = (c > 1) && (pos == 0);

    tests++;
    assert (dig_sel === e_sel) else begin
      fails++; $error("FAIL dig_sel c=%0d got %h exp %h", c, dig_sel, e_sel);
    end
    tests++;
    assert (dec_in === e_in) else begin
      fails++; $error("FAIL dec_in c=%0d got %h exp %h", c, dec_in, e_in);
    end
    tests++;
    assert (dec_en === e_en) else begin
      fails++; $error("FAIL dec_en c=%0d got %b exp %b", c, dec_en, e_en);
    end
    tests++;
    assert (frame_tick === e_ft) else begin
      fails++; $error("FAIL frame_tick c=%0d got %b exp %b", c, frame_tick, e_ft);
    end
  endtask

  // Apply the currently driven inputs for one cycle and check the next one.
  task automatic cycle();
    p_dig  = s_dig;
    p_vis  = s_vis;
    p_mask = blink_mask;
    if (rst || clr_en) begin
      model_clear();
    end else if (push_en) begin
      for (int i = ND - 1; i > 0; i--) begin
        s_dig[i] = s_dig[i-1];
        s_vis[i] = s_vis[i-1];
      end
      s_dig[0] = push_data;
      s_vis[0] = 1'b1;
    end else if (wr_en && (int'(wr_idx) < ND)) begin
      s_dig[wr_idx] = wr_data;
      s_vis[wr_idx] = wr_vis;
    end
    @(posedge clk);
    #1;
    c = rst ? 1 : c + 1;
    check_outputs();
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0; push_en = 1'b0; clr_en = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_push(input logic [3:0] v);
    push_en = 1'b1; push_data = v;
    cycle();
    idle();
  endtask

  task automatic do_write(input logic [IW-1:0] i, input logic [3:0] v, input logic vis);
    wr_en = 1'b1; wr_idx = i; wr_data = v; wr_vis = vis;
    cycle();
    idle();
  endtask

  function automatic bit at_phase1_digit2_drive(input int cc);
    int pos;
    pos = (cc - 1) % FR;
    return ((((cc - 1) / FR / BF) % 2) == 1) && (pos / SD == 2) && (pos % SD != 0);
  endfunction

  initial begin
    int guard;
    idle();
    rst = 1'b1;
    wr_idx = '0; wr_data = 4'h0; wr_vis = 1'b0; push_data = 4'h0;
    blink_mask = '0;
    model_clear();
    p_dig = s_dig; p_vis = s_vis; p_mask = '0;

    // Reset held for a few edges, then free-running scan with empty storage.
    run(3);
    rst = 1'b0;
    run(2 * FR);

    // Single write to digit 2, then observe a full frame.
    do_write(2'd2, 4'h7, 1'b1);
    run(FR + 4);

    // Keypad entry 1,2,3.
    do_push(4'h1);
    do_push(4'h2);
    do_push(4'h3);
    run(FR + 4);

    // All three commands together: clear wins.
    clr_en = 1'b1; push_en = 1'b1; push_data = 4'h9;
    wr_en = 1'b1; wr_idx = 2'd1; wr_data = 4'hA; wr_vis = 1'b1;
    cycle();
    idle();
    run(FR);

    // push + write together: only the shift lands.
    do_push(4'h5);
    push_en = 1'b1; push_data = 4'hC;
    wr_en = 1'b1; wr_idx = 2'd3; wr_data = 4'hE; wr_vis = 1'b1;
    cycle();
    idle();
    run(FR + 4);

    // Blink: every digit visible, digit 0 masked, watch six frames.
    clr_en = 1'b1; cycle(); idle();
    do_push(4'h4); do_push(4'h3); do_push(4'h2); do_push(4'h1);
    blink_mask = 4'b0001;
    run(6 * FR);

    // Reset during digit-2 DRIVE of a phase-1 half-period, with a command
    // in the same cycle that the reset must override.
    guard = 0;
    while (!at_phase1_digit2_drive(c) && guard < 8 * FR) begin
      cycle();
      guard++;
    end
    tests++;
    assert (guard < 8 * FR) else begin
      fails++; $error("FAIL align_rst guard=%0d exp <%0d", guard, 8 * FR);
    end
    rst = 1'b1; push_en = 1'b1; push_data = 4'hF;
    cycle();
    idle();
    // After reset the blink phase starts at 0: digit 0 shows for two frames.
    do_push(4'h8); do_push(4'h7); do_push(4'h6); do_push(4'h5);
    run(3 * FR);

    // Random command mix.
    for (int k = 0; k < 1500; k++) begin
      rst       = ($urandom_range(0, 299) == 0);
      clr_en    = ($urandom_range(0, 19) == 0);
      push_en   = ($urandom_range(0, 4) == 0);
      push_data = 4'($urandom);
      wr_en     = ($urandom_range(0, 2) == 0);
      wr_idx    = IW'($urandom);
      wr_data   = 4'($urandom);
      wr_vis    = 1'($urandom);
      if ($urandom_range(0, 49) == 0) blink_mask = ND'($urandom);
      cycle();
    end
    idle();
    run(FR);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
